// File: rtl/serial_link_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_link_pkg                                                    |
// | Shared constants, state encodings and checksum helper for the      |
// | host serial link transmit path.                                    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package serial_link_pkg;

  // First byte of every packet
  localparam logic [7:0] C_HEADER    = 8'hA5;
  // Bytes per packet: header, flags/level/score MSBs, score LSBs, checksum
  localparam int         C_PKT_BYTES = 4;
  localparam logic [1:0] C_LAST_BYTE = 2'(C_PKT_BYTES - 1);

  // Debug state codes shown on db_estado
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_DATA  = 4'd2,
    ST_STOP  = 4'd3,
    ST_NEXT  = 4'd4
  } tx_state_e;

  // Byte sequencer states kept by the top
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_SEND = 2'd1,
    SEQ_NEXT = 2'd2
  } seq_state_e;

  // Packet checksum: plain XOR of the three preceding bytes
  function automatic logic [7:0] checksum(input logic [7:0] h,
                                          input logic [7:0] b1,
                                          input logic [7:0] b2);
    return h ^ b1 ^ b2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_byte                                                       |
// | 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit,  |
// | each held BAUD_DIV clocks. fim flags the last stop-bit cycle.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module uart_tx_byte
  import serial_link_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inicio,
  input  logic [7:0] dado,
  output logic       serial,
  output logic       fim,
  output tx_state_e  estado
);

  localparam int            CW          = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] C_BAUD_LAST = CW'(BAUD_DIV - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          w_baud_end;

  assign w_baud_end = (cnt_q == C_BAUD_LAST);

  // Bit timing and line value; serial is registered so the line is glitch-free
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    fim      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        if (inicio) begin
          state_d  = ST_START;
          cnt_d    = '0;
          bit_d    = 3'd0;
          shift_d  = dado;
          serial_d = 1'b0;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          cnt_d    = '0;
          state_d  = ST_DATA;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d  = ST_STOP;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (w_baud_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          fim     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase
  end

  // State register; reset forces the line idle-high on the next edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
    end
  end

  assign serial = serial_q;
  assign estado = state_q;

endmodule
`default_nettype wire

// File: rtl/serial_placar_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_placar_tx                                                   |
// | Sends a 4-byte status packet (header, flags/level/score MSBs,      |
// | score LSBs, checksum) as 8N1 UART on each score event or request.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module serial_placar_tx
  import serial_link_pkg::*;
#(
  parameter int         BAUD_DIV = 434,
  parameter logic [7:0] HEADER   = C_HEADER
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       envia,
  input  logic       ganhou_ponto,
  input  logic       perdeu_ponto,
  input  logic [9:0] pontuacao,
  input  logic [1:0] nivel_dificuldade,
  output logic       serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  seq_state_e seq_q, seq_d;
  logic [1:0] byte_q, byte_d;
  logic [7:0] b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
  logic       fg_q, fg_d, fp_q, fp_d, pending_q, pending_d;
  logic       ocupado_q, ocupado_d, pronto_q, pronto_d;

  logic       w_req, w_snap, w_busy;
  logic [7:0] w_b1, w_b2;
  logic [1:0] w_byte_nxt;
  logic [7:0] w_byte_sel;
  logic       w_inicio;
  logic [7:0] w_dado;
  logic       w_fim;
  tx_state_e  w_tx_estado;

  assign w_req  = envia | ganhou_ponto | perdeu_ponto;
  assign w_busy = (seq_q != SEQ_IDLE);
  // Snapshot only from IDLE; a pulse on this very cycle lands in this packet
  assign w_snap = !w_busy && (w_req || pending_q);
  assign w_b1   = {nivel_dificuldade, fg_q | ganhou_ponto, fp_q | perdeu_ponto,
                   2'b00, pontuacao[9:8]};
  assign w_b2   = pontuacao[7:0];

  // Packet snapshot, sticky event flags and coalesced pending request
  always_comb begin
    b1_d      = b1_q;
    b2_d      = b2_q;
    b3_d      = b3_q;
    fg_d      = fg_q | ganhou_ponto;
    fp_d      = fp_q | perdeu_ponto;
    pending_d = pending_q | (w_req & w_busy);
    if (w_snap) begin
      b1_d      = w_b1;
      b2_d      = w_b2;
      b3_d      = checksum(HEADER, w_b1, w_b2);
      fg_d      = 1'b0;
      fp_d      = 1'b0;
      pending_d = 1'b0;
    end
  end

  // Byte that follows the current one in packet order
  assign w_byte_nxt = byte_q + 2'd1;
  always_comb begin
    w_byte_sel = HEADER;
    case (w_byte_nxt)
      2'd1:    w_byte_sel = b1_q;
      2'd2:    w_byte_sel = b2_q;
      2'd3:    w_byte_sel = b3_q;
      default: w_byte_sel = HEADER;
    endcase
  end

  // Byte sequencer: launch header on snapshot, one gap cycle between bytes
  always_comb begin
    seq_d     = seq_q;
    byte_d    = byte_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;
    w_inicio  = 1'b0;
    w_dado    = HEADER;
    case (seq_q)
      SEQ_IDLE: begin
        if (w_snap) begin
          seq_d     = SEQ_SEND;
          byte_d    = 2'd0;
          ocupado_d = 1'b1;
          w_inicio  = 1'b1;
        end
      end
      SEQ_SEND: begin
        if (w_fim) begin
          seq_d = SEQ_NEXT;
        end
      end
      SEQ_NEXT: begin
        if (byte_q == C_LAST_BYTE) begin
          seq_d     = SEQ_IDLE;
          ocupado_d = 1'b0;
          pronto_d  = 1'b1;
        end else begin
          seq_d    = SEQ_SEND;
          byte_d   = w_byte_nxt;
          w_inicio = 1'b1;
          w_dado   = w_byte_sel;
        end
      end
      default: begin
        seq_d     = SEQ_IDLE;
        ocupado_d = 1'b0;
      end
    endcase
  end

  // Sequencer and snapshot registers
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q     <= SEQ_IDLE;
      byte_q    <= 2'd0;
      b1_q      <= 8'h00;
      b2_q      <= 8'h00;
      b3_q      <= 8'h00;
      fg_q      <= 1'b0;
      fp_q      <= 1'b0;
      pending_q <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      byte_q    <= byte_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      b3_q      <= b3_d;
      fg_q      <= fg_d;
      fp_q      <= fp_d;
      pending_q <= pending_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx_byte (
    .clock  (clock),
    .reset  (reset),
    .inicio (w_inicio),
    .dado   (w_dado),
    .serial (serial),
    .fim    (w_fim),
    .estado (w_tx_estado)
  );

  // Debug code: bit phase while a byte is on the line, else sequencer state
  always_comb begin
    db_estado = ST_IDLE;
    case (seq_q)
      SEQ_SEND: db_estado = w_tx_estado;
      SEQ_NEXT: db_estado = ST_NEXT;
      default:  db_estado = ST_IDLE;
    endcase
  end

  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;

endmodule
`default_nettype wire
